// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port between
// an ALU requester (A) and a load requester (B), round-robin or fixed priority.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned FIXED_PRI = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              last_grant,
    output logic [CNT_W-1:0]  wr_count
);

    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_wr_count;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_win_reg;
    logic [DATA_W-1:0] w_win_data;
    logic              w_nonzero;

    // Grant selection: at most one ready, none while in reset
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (!reset) begin
            if (a_valid && b_valid) begin
                w_grant_b = (FIXED_PRI != 0) || !r_last_grant;
                w_grant_a = !w_grant_b;
            end else begin
                w_grant_a = a_valid;
                w_grant_b = b_valid;
            end
        end
    end

    // Winner mux; the grant implies the matching valid, so ready == transfer
    always_comb begin
        w_xfer     = w_grant_a || w_grant_b;
        w_win_reg  = w_grant_b ? b_reg  : a_reg;
        w_win_data = w_grant_b ? b_data : a_data;
        w_nonzero  = (w_win_reg != ADDR_W'(0));
    end

    // Commit register: capture winner, suppress $0 writes, count real commits
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_last_grant <= 1'b1;
            r_wr_count   <= '0;
        end else if (w_xfer) begin
            r_reg_write  <= w_nonzero;
            r_write_reg  <= w_win_reg;
            r_write_data <= w_win_data;
            r_last_grant <= w_grant_b;
            if (w_nonzero) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end else begin
            r_reg_write <= 1'b0;
        end
    end

    assign a_ready    = w_grant_a;
    assign b_ready    = w_grant_b;
    assign regWrite   = r_reg_write;
    assign writeReg   = r_write_reg;
    assign writeData  = r_write_data;
    assign last_grant = r_last_grant;
    assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: round-robin instance plus a
// fixed-priority instance with its own requester inputs.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        last_grant;
    logic [15:0] wr_count;

    logic        f_a_valid, f_b_valid;
    logic [4:0]  f_a_reg, f_b_reg;
    logic [31:0] f_a_data, f_b_data;
    logic        f_a_ready, f_b_ready;
    logic        f_regWrite;
    logic [4:0]  f_writeReg;
    logic [31:0] f_writeData;
    logic        f_last_grant;
    logic [15:0] f_wr_count;

    int          checks = 0;
    int          errors = 0;
    logic [36:0] exp_q[$];
    logic [31:0] rf[32];
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRI(0), .CNT_W(16)) u_rr (
        .clock_in(clk), .reset(reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .last_grant(last_grant), .wr_count(wr_count)
    );

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIXED_PRI(1), .CNT_W(16)) u_fp (
        .clock_in(clk), .reset(reset),
        .a_valid(f_a_valid), .a_reg(f_a_reg), .a_data(f_a_data), .a_ready(f_a_ready),
        .b_valid(f_b_valid), .b_reg(f_b_reg), .b_data(f_b_data), .b_ready(f_b_ready),
        .regWrite(f_regWrite), .writeReg(f_writeReg), .writeData(f_writeData),
        .last_grant(f_last_grant), .wr_count(f_wr_count)
    );

    // Register-file model fed by the write port; compares every commit to the scoreboard
    always @(negedge clk) begin
        if (regWrite === 1'b1) begin
            logic [36:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got reg=%0d data=%h, expected no write", writeReg, writeData);
            end else begin
                e = exp_q.pop_front();
                if ({writeReg, writeData} !== e) begin
                    errors++;
                    $display("FAIL commit got reg=%0d data=%h, expected reg=%0d data=%h",
                             writeReg, writeData, e[36:32], e[31:0]);
                end
            end
            rf[writeReg] = writeData;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ready(input string name, input logic ea, input logic eb);
        #1;
        checks++;
        if ({a_ready, b_ready} !== {ea, eb}) begin
            errors++;
            $display("FAIL %s ready got a=%b b=%b, expected a=%b b=%b", name, a_ready, b_ready, ea, eb);
        end
    endtask

    task automatic check_state(input string name, input logic exp_last);
        checks++;
        if (wr_count !== 16'(exp_cnt) || last_grant !== exp_last) begin
            errors++;
            $display("FAIL %s state got cnt=%0d last=%b, expected cnt=%0d last=%b",
                     name, wr_count, last_grant, exp_cnt, exp_last);
        end
    endtask

    task automatic drain(input string name);
        next_cycle();
        next_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending got %0d outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h22;
        f_a_valid = 1'b1; f_b_valid = 1'b1;
        f_a_reg = 5'd1; f_b_reg = 5'd2; f_a_data = 32'h0; f_b_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            check_ready("reset", 1'b0, 1'b0);
        end
        checks++;
        if (regWrite !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0 ||
            wr_count !== 16'd0 || last_grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got we=%b reg=%0d data=%h cnt=%0d last=%b, expected 0 0 0 0 1",
                     regWrite, writeReg, writeData, wr_count, last_grant);
        end
        checks++;
        if (f_a_ready !== 1'b0 || f_b_ready !== 1'b0 || f_last_grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_fp got a=%b b=%b last=%b, expected 0 0 1", f_a_ready, f_b_ready, f_last_grant);
        end
        reset = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; f_a_valid = 1'b0; f_b_valid = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_reg = 5'd21; a_data = 32'hFAFA0C0C;
        check_ready("single_a", 1'b1, 1'b0);
        exp_q.push_back({5'd21, 32'hFAFA0C0C}); exp_cnt++;
        next_cycle();
        a_valid = 1'b0;
        checks++;
        if (regWrite !== 1'b1 || writeReg !== 5'd21 || writeData !== 32'hFAFA0C0C) begin
            errors++;
            $display("FAIL single_out got we=%b reg=%0d data=%h, expected 1 21 fafa0c0c",
                     regWrite, writeReg, writeData);
        end
        check_state("single_a", 1'b0);
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h0000BEEF;
        check_ready("single_b", 1'b0, 1'b1);
        exp_q.push_back({5'd7, 32'h0000BEEF}); exp_cnt++;
        next_cycle();
        b_valid = 1'b0;
        check_state("single_b", 1'b1);
        drain("single");
    endtask

    task automatic test_contention();
        a_valid = 1'b1; a_reg = 5'd10; a_data = 32'hABCDABCD;
        b_valid = 1'b1; b_reg = 5'd10; b_data = 32'h12345678;
        check_ready("contend_1", 1'b1, 1'b0);
        exp_q.push_back({5'd10, 32'hABCDABCD}); exp_cnt++;
        next_cycle();
        a_valid = 1'b0;
        check_ready("contend_2", 1'b0, 1'b1);
        exp_q.push_back({5'd10, 32'h12345678}); exp_cnt++;
        next_cycle();
        b_valid = 1'b0;
        check_state("contend", 1'b1);
        drain("contend");
        checks++;
        if (rf[10] !== 32'h12345678) begin
            errors++;
            $display("FAIL contend_final got reg10=%h, expected 12345678", rf[10]);
        end
    endtask

    task automatic test_back_to_back();
        a_valid = 1'b1; a_reg = 5'd1; a_data = 32'hA0000000;
        b_valid = 1'b1; b_reg = 5'd2; b_data = 32'hB0000000;
        for (int k = 0; k < 6; k++) begin
            logic a_turn;
            a_turn = (k % 2 == 0);
            check_ready("b2b", a_turn, !a_turn);
            if (a_turn) exp_q.push_back({a_reg, a_data});
            else        exp_q.push_back({b_reg, b_data});
            exp_cnt++;
            next_cycle();
            if (a_turn) begin a_reg = a_reg + 5'd2; a_data = a_data + 32'd1; end
            else        begin b_reg = b_reg + 5'd2; b_data = b_data + 32'd1; end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        check_state("b2b", 1'b1);
        drain("b2b");
    endtask

    task automatic test_withdraw();
        a_valid = 1'b1; a_reg = 5'd12; a_data = 32'hCAFE0001;
        b_valid = 1'b1; b_reg = 5'd13; b_data = 32'hDEAD0002;
        check_ready("withdraw", 1'b1, 1'b0);
        exp_q.push_back({5'd12, 32'hCAFE0001}); exp_cnt++;
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        check_ready("withdraw_idle", 1'b0, 1'b0);
        next_cycle();
        checks++;
        if (regWrite !== 1'b0 || writeReg !== 5'd12 || writeData !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL withdraw_hold got we=%b reg=%0d data=%h, expected 0 12 cafe0001",
                     regWrite, writeReg, writeData);
        end
        check_state("withdraw", 1'b0);
        drain("withdraw");
    endtask

    task automatic test_zero();
        b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFFFFFF;
        check_ready("zero", 1'b0, 1'b1);
        next_cycle();
        b_valid = 1'b0;
        checks++;
        if (regWrite !== 1'b0) begin
            errors++;
            $display("FAIL zero_we got %b, expected 0", regWrite);
        end
        check_state("zero", 1'b1);
        drain("zero");
        checks++;
        if (rf[0] !== 32'd0) begin
            errors++;
            $display("FAIL zero_reg got reg0=%h, expected 0", rf[0]);
        end
    endtask

    task automatic test_fixed_pri();
        f_a_valid = 1'b1; f_a_reg = 5'd5; f_a_data = 32'h55;
        f_b_valid = 1'b1; f_b_reg = 5'd6;
        for (int k = 1; k <= 3; k++) begin
            f_b_data = 32'(k);
            #1;
            checks++;
            if (f_a_ready !== 1'b0 || f_b_ready !== 1'b1) begin
                errors++;
                $display("FAIL fixed_ready got a=%b b=%b, expected a=0 b=1", f_a_ready, f_b_ready);
            end
            next_cycle();
            checks++;
            if (f_regWrite !== 1'b1 || f_writeReg !== 5'd6 || f_writeData !== 32'(k) || f_last_grant !== 1'b1) begin
                errors++;
                $display("FAIL fixed_commit got we=%b reg=%0d data=%h last=%b, expected 1 6 %h 1",
                         f_regWrite, f_writeReg, f_writeData, f_last_grant, 32'(k));
            end
        end
        f_a_valid = 1'b0; f_b_valid = 1'b0;
        next_cycle();
        checks++;
        if (f_wr_count !== 16'd3) begin
            errors++;
            $display("FAIL fixed_count got %0d, expected 3", f_wr_count);
        end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_reg = 5'd9; a_data = 32'h99999999;
        check_ready("mid", 1'b1, 1'b0);
        exp_q.push_back({5'd9, 32'h99999999}); exp_cnt++;
        next_cycle();
        reset = 1'b1;
        check_ready("mid_rst", 1'b0, 1'b0);
        next_cycle();
        reset = 1'b0; a_valid = 1'b0;
        exp_cnt = 0;
        checks++;
        if (regWrite !== 1'b0) begin
            errors++;
            $display("FAIL mid_we got %b, expected 0", regWrite);
        end
        check_state("mid", 1'b1);
        drain("mid");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_withdraw();
        test_zero();
        test_fixed_pri();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
